// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: SRAM-like data bus (req / addr_ok / data_ok handshake)
//   master: drives data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
//           and receives data_addr_ok, data_data_ok, data_rdata
//   slave : the opposite directions
interface dmem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto the data bus and stalls until each completes
//   clk, reset          : clock, synchronous active-high reset
//   mem_valid/memR/memW : MEM-stage access request (load wins when both types are set)
//   addr/wdata/flush    : effective address, unaligned store data, cancel current access
//   bus                 : data-bus master port
//   stall/done/rdata    : pipeline freeze, one-cycle completion pulse, extracted load data
//   ade_l/ade_s/bus_err : load/store address-error pulses, response-timeout pulse
module dmem_access_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic [1:0]                 memR,
    input  logic [1:0]                 memW,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    input  logic                       flush,
    dmem_access_ctrl_if.master         bus,
    output logic                       stall,
    output logic                       done,
    output logic [31:0]                rdata,
    output logic                       ade_l,
    output logic                       ade_s,
    output logic                       bus_err
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;
    stateT state, nextState;
    logic [1:0] kind, kindR, offR;
    logic isLoad, access, misaligned, accept, timeout, cancel, loadR;
    logic [CW-1:0] cnt;
    logic [31:0] shifted, extracted;
    assign isLoad = memR != 2'd0;
    assign kind = isLoad ? memR : memW;
    assign access = mem_valid && kind != 2'd0;
    assign misaligned = (kind == 2'd2 && addr[0]) || (kind == 2'd3 && addr[1:0] != 2'd0);
    assign accept = state == IDLE && access && !misaligned && !flush;
    // a response arriving on the last allowed cycle still wins over the timeout
    assign timeout = TIMEOUT != 0 && state == WAIT && !bus.data_data_ok && cnt == CW'(TIMEOUT - 1);
    // halves are always aligned, so the byte-offset shift also lands them in [15:0]
    assign shifted = bus.data_rdata >> {offR, 3'b000};
    assign extracted = kindR == 2'd1 ? {{24{shifted[7]}}, shifted[7:0]} :
                       kindR == 2'd2 ? {{16{shifted[15]}}, shifted[15:0]} : bus.data_rdata;
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = accept ? REQ : IDLE;
            REQ: nextState = bus.data_addr_ok ? (bus.data_data_ok ? (flush ? IDLE : DONE) : WAIT) :
                             (flush ? IDLE : REQ);
            WAIT: nextState = bus.data_data_ok ? ((cancel || flush) ? IDLE : DONE) :
                              (timeout ? IDLE : WAIT);
            default: nextState = IDLE;
        endcase
        bus.data_req = state == REQ;
        done = state == DONE;
        bus_err = timeout;
        stall = access && state != DONE && !(misaligned && state == IDLE) && !flush;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            kindR <= '0;
            offR <= '0;
            loadR <= 1'b0;
            cancel <= 1'b0;
            cnt <= '0;
            rdata <= '0;
            ade_l <= 1'b0;
            ade_s <= 1'b0;
            bus.data_wr <= 1'b0;
            bus.data_size <= '0;
            bus.data_addr <= '0;
            bus.data_wstrb <= '0;
            bus.data_wdata <= '0;
        end else begin
            state <= nextState;
            ade_l <= state == IDLE && access && misaligned && !flush && isLoad;
            ade_s <= state == IDLE && access && misaligned && !flush && !isLoad;
            cnt <= state == WAIT ? cnt + 1'b1 : '0;
            // a flushed access still owes the bus its response; remember to discard it
            cancel <= nextState == WAIT && (cancel || flush);
            if (accept) begin
                kindR <= kind;
                offR <= addr[1:0];
                loadR <= isLoad;
                bus.data_wr <= !isLoad;
                bus.data_size <= kind - 2'd1;
                bus.data_addr <= addr;
                bus.data_wstrb <= isLoad ? 4'b0000 : kind == 2'd1 ? 4'b0001 << addr[1:0] :
                                  kind == 2'd2 ? 4'b0011 << addr[1:0] : 4'b1111;
                bus.data_wdata <= wdata << {addr[1:0], 3'b000};
            end
            if (nextState == DONE && loadR)
                rdata <= extracted;
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with random loads/stores against a byte-level reference model
module tb_dmem_access_ctrl;
    logic clk, reset, mem_valid, flush;
    logic [1:0] memR, memW;
    logic [31:0] addr, wdata, rdata;
    logic stall, done, ade_l, ade_s, bus_err;
    dmem_access_ctrl_if bus();
    dmem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .memR(memR), .memW(memW),
        .addr(addr), .wdata(wdata), .flush(flush), .bus(bus), .stall(stall),
        .done(done), .rdata(rdata), .ade_l(ade_l), .ade_s(ade_s), .bus_err(bus_err)
    );
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } reqT;
    typedef struct {
        int          ev;
        logic [31:0] rd;
    } respT;
    reqT reqQ[$];
    respT respQ[$];
    int checks = 0, failures = 0;
    bit monOn = 0;
    logic [31:0] lastRd = '0;
    reqT mReq;
    respT mResp;
    int mEv;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (monOn) begin
            if (bus.data_req) begin
                if (reqQ.size() == 0) chk("unexpected_req", 32'(bus.data_addr), 32'hFFFF_FFFF);
                else begin
                    mReq = reqQ[0];
                    chk("req_ctl", 32'({bus.data_wr, bus.data_size, bus.data_wstrb}),
                        32'({mReq.wr, mReq.size, mReq.wstrb}));
                    chk("req_addr", bus.data_addr, mReq.addr);
                    if (mReq.wr) chk("req_wdata", bus.data_wdata, mReq.wdata);
                    if (bus.data_addr_ok) void'(reqQ.pop_front());
                end
            end
            mEv = done ? 1 : ade_l ? 2 : ade_s ? 3 : bus_err ? 4 : 0;
            if (mEv != 0) begin
                if (respQ.size() == 0) chk("unexpected_resp", 32'(mEv), 0);
                else begin
                    mResp = respQ.pop_front();
                    chk("resp_event", 32'({done, ade_l, ade_s, bus_err}),
                        32'(4'b1000 >> (mResp.ev - 1)));
                    if (mResp.ev == 1) chk("resp_rdata", rdata, mResp.rd);
                end
            end
        end
    end
    task automatic runOp(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw,
                         input int aDly, input int dDly, input bit fl);
        int code, nb, off, k, ph, aCyc;
        bit ld, mis, fin, fsent;
        longint v;
        reqT q;
        respT e;
        code = r != 0 ? int'(r) : int'(w);
        ld = r != 0;
        @(posedge clk);
        #1;
        mem_valid = 1; memR = r; memW = w; addr = a; wdata = wd; bus.data_rdata = rw;
        if (code == 0) begin
            #1 chk("noop_stall", 32'(stall), 0);
            @(posedge clk);
            #1 mem_valid = 0;
            return;
        end
        nb = 1 << (code - 1);
        off = int'(a[1:0]);
        mis = (off % nb) != 0;
        if (mis) begin
            e.ev = ld ? 2 : 3; e.rd = '0;
            respQ.push_back(e);
            #1 chk("mis_stall", 32'(stall), 0);
            @(posedge clk);
            #1 mem_valid = 0;
            #1 chk("mis_no_req", 32'({bus.data_req, done}), 0);
            @(posedge clk);
            return;
        end
        q.wr = !ld;
        q.size = 2'(code - 1);
        q.addr = a;
        q.wstrb = ld ? 4'd0 : 4'(((1 << nb) - 1) << off);
        q.wdata = wd << (8 * off);
        reqQ.push_back(q);
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'((rw >> (8 * (off + i))) & 32'hFF) << (8 * i);
        if (nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        if (dDly >= 100) begin
            e.ev = 4; e.rd = '0;
            respQ.push_back(e);
        end else if (!fl) begin
            if (ld) lastRd = 32'(v);
            e.ev = 1; e.rd = lastRd;
            respQ.push_back(e);
        end
        #1 chk("stall_issue", 32'(stall), 1);
        ph = 0; k = 0; fin = 0; fsent = 0; aCyc = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(posedge clk);
            #1 bus.data_addr_ok = 0; bus.data_data_ok = 0; flush = 0;
            #1;
            if (done) begin
                chk("latency", 32'(c - aCyc), dDly == 0 ? 1 : dDly + 1);
                chk("stall_done", 32'(stall), 0);
                mem_valid = 0;
                fin = 1;
            end else if (ph >= 2) begin
                chk(ph == 2 ? "cancel_idle" : "timeout_idle", 32'({done, stall, bus.data_req, bus_err}), 0);
                fin = 1;
            end else if (ph == 0) begin
                chk("stall_busy", 32'(stall), 1);
                if (c == 0) chk("req_next_cycle", 32'(bus.data_req), 1);
                if (bus.data_req) begin
                    if (k == aDly) begin
                        bus.data_addr_ok = 1; aCyc = c; ph = 1; k = 0;
                        if (dDly == 0) bus.data_data_ok = 1;
                    end else k++;
                end
            end else begin
                k++;
                if (!fsent) chk("stall_busy", 32'(stall), 1);
                if (bus_err) begin
                    chk("timeout_cycle", 32'(k), 4);
                    mem_valid = 0;
                    ph = 3;
                end else if (k == dDly) begin
                    bus.data_data_ok = 1;
                    if (fl) ph = 2;
                end else if (fl && k == 1) begin
                    flush = 1; mem_valid = 0; fsent = 1;
                end
            end
        end
        if (!fin) chk("txn_bound", 32'(ph), 32'hFFFF_FFFF);
        bus.data_addr_ok = 0; bus.data_data_ok = 0; flush = 0; mem_valid = 0;
    endtask
    initial begin
        reset = 1; mem_valid = 0; flush = 0; memR = 0; memW = 0; addr = 0; wdata = 0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("rst_bus_ctl", 32'({bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb}), 0);
        chk("rst_addr", bus.data_addr, 0);
        chk("rst_wdata", bus.data_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulses", 32'({done, ade_l, ade_s, bus_err, stall}), 0);
        monOn = 1;
        runOp(2'd1, 2'd0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1, 0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        runOp(2'd0, 2'd2, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3, 1, 0);
        chk("sh_keeps_rdata", rdata, 32'hFFFF_FF80);
        runOp(2'd3, 2'd0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 0);
        runOp(2'd2, 2'd0, 32'h0000_4000, 32'h0, 32'h0000_7FFE, 0, 0, 0);
        chk("lh_rdata", rdata, 32'h0000_7FFE);
        runOp(2'd0, 2'd3, 32'h0000_5000, 32'h1234_5678, 32'h0, 0, 3, 1);
        runOp(2'd3, 2'd0, 32'h0000_6004, 32'h0, 32'hCAFE_BABE, 1, 2, 0);
        chk("lw_after_flush", rdata, 32'hCAFE_BABE);
        runOp(2'd3, 2'd0, 32'h0000_7000, 32'h0, 32'h0, 0, 100, 0);
        for (int n = 0; n < 80; n++) begin
            int dd;
            dd = $urandom_range(0, 3);
            runOp(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), dd, dd >= 2 && $urandom_range(0, 5) == 0);
        end
        monOn = 0;
        @(posedge clk);
        #1 mem_valid = 1; memR = 2'd3; memW = 2'd0; addr = 32'h0000_8000;
        @(posedge clk);
        #2 chk("rst_req_up", 32'(bus.data_req), 1);
        reset = 1; mem_valid = 0;
        @(posedge clk);
        #1 reset = 0;
        #1 chk("rst_req_dropped", 32'({bus.data_req, done, stall}), 0);
        chk("rst_addr_cleared", bus.data_addr, 0);
        bus.data_data_ok = 1;
        @(posedge clk);
        #1 bus.data_data_ok = 0;
        #1 chk("rst_resp_ignored", 32'({done, bus.data_req}), 0);
        reqQ.delete();
        respQ.delete();
        lastRd = '0;
        monOn = 1;
        runOp(2'd3, 2'd0, 32'h0000_9008, 32'h0, 32'h0BAD_F00D, 2, 1, 0);
        chk("lw_after_reset", rdata, 32'h0BAD_F00D);
        repeat (2) @(posedge clk);
        chk("queues_drained", 32'(reqQ.size() + respQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto the SRAM-like data bus (req / addr_ok / data_ok handshake).
- Generates byte strobes, performs load extraction and sign extension, detects address errors, and stalls the pipeline until each access completes.
- Sits between the MEM stage and the data-bus port of the CPU top.

Parameters:
- TIMEOUT, 256, max cycles waiting in WAIT for data_data_ok before aborting with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_valid  in  1  MEM stage holds a valid instruction; held stable while stall=1
- memR  in  2  load type: 00 none, 01 lb, 10 lh, 11 lw
- memW  in  2  store type: 00 none, 01 sb, 10 sh, 11 sw
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (busB), unaligned in bits [7:0] / [15:0]
- flush  in  1  cancel current MEM instruction (exception / eret)
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address (= addr, unmodified)
- data_wstrb  out  4  byte enables
- data_wdata  out  32  store data shifted left by 8*addr[1:0]
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / write completion
- data_rdata  in  32  raw read word
- stall  out  1  freeze pipeline up to MEM
- done  out  1  one-cycle pulse, access complete
- rdata  out  32  extracted load data, valid when done=1
- ade_l  out  1  load address error pulse
- ade_s  out  1  store address error pulse
- bus_err  out  1  timeout pulse

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0 (data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, done, rdata, ade_l, ade_s, bus_err).
  - Timeout counter 0.
- Access present = mem_valid & (memR!=0 | memW!=0). If memR and memW are both nonzero, the load takes priority.
- Misalignment:
  - Half-word access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Byte access is never misaligned.
- stall (combinational) = access present & ~done & ~(misaligned in IDLE) & ~flush.
- States:
  - IDLE:
    - Access present, aligned, no flush -> latch type, offset and bus fields into registers; data_req=1 next cycle; go to REQ.
    - Misaligned -> pulse ade_l or ade_s next cycle; no bus request; stay in IDLE.
  - REQ:
    - data_req=1 and all bus outputs held stable until data_addr_ok.
    - addr_ok=1 -> data_req=0 next cycle, go to WAIT.
    - addr_ok and data_ok in the same cycle -> complete directly (go to DONE).
    - flush with addr_ok=0 -> drop data_req, go to IDLE, no done.
  - WAIT:
    - Counter increments each cycle.
    - data_data_ok -> register extracted rdata, go to DONE.
    - Counter reaches TIMEOUT (TIMEOUT≠0) -> bus_err pulse, go to IDLE.
    - flush in WAIT -> set a cancel flag, still wait for data_ok, then go to IDLE with no done and no rdata update (response discarded).
  - DONE: done=1 for exactly one cycle, go to IDLE. The MEM stage advances on this cycle; a new request is not accepted in DONE.
- Store fields:
  - sb: wstrb = 0001 << off, size 0.
  - sh: wstrb = 0011 << off, size 1.
  - sw: wstrb = 1111, size 2.
  - data_wr = 1 for all stores; data_wdata = wdata << 8*off, where off = addr[1:0].
- Load extraction (from latched offset):
  - lb: byte[off] sign-extended from its bit 7.
  - lh: half[off/2] sign-extended.
  - lw: word as-is.
  - Loads set data_wstrb=0, data_wr=0.
- Store completion also requires data_data_ok; rdata is unchanged on stores.
- Latency (zero-wait bus): mem_valid at cycle N -> data_req at N+1 -> addr_ok at N+1 -> data_ok at N+2 -> done at N+3.
- Reset mid-operation (any state): IDLE next cycle; outstanding response ignored.

Test Plan:
- lb, addr=0x1003, rdata=0x80FF_1234, zero-wait bus -> data_req at N+1 with size 0, wstrb 0000; done at N+3 with rdata=0xFFFF_FF80; stall high N..N+2.
- sh, addr=0x2002, wdata=0x0000_ABCD -> data_wstrb=1100, data_wdata=0xABCD_0000, data_wr=1; addr_ok held off 3 cycles -> bus fields stable throughout, done 2 cycles after addr_ok.
- lw, addr=0x3001 -> ade_l pulse at N+1, data_req never asserts, stall low, done 0.
- lh, addr=0x4000, addr_ok and data_ok in same cycle, rdata=0x0000_7FFE -> done next cycle, rdata=0x0000_7FFE.
- sw accepted, flush asserted in WAIT, data_ok 2 cycles later -> no done, state IDLE; following lw completes normally.
- TIMEOUT=4, lw accepted, data_ok never arrives -> bus_err pulse at the 4th WAIT cycle, IDLE next; reset asserted during REQ -> data_req=0 the next cycle.
